// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: single memory bus shared by fetch and data accesses.
// Master is mem_arbiter; slave is the memory system.
interface mem_arbiter_if;
   // Handshake: the master raises bus_req with addr/we/wdata/byte_sel and
   // holds all of them stable until the slave answers with bus_ack=1 for one
   // sampled cycle (bus_rdata valid in that cycle); bus_ack while bus_req=0
   // carries no meaning and is ignored.
   logic        bus_req;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [31:0] bus_wdata;
   logic [1:0]  bus_byte_sel;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_addr, bus_we, bus_wdata, bus_byte_sel,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_addr, bus_we, bus_wdata, bus_byte_sel,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and data load/store.
// Define MEM_ARB_TIMEOUT_EN to abort bus transactions after 255 unacknowledged cycles.
module mem_arbiter (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   fetch_addr,
   input  logic [31:0]   mem_addr,
   input  logic [31:0]   mem_wdata,
   input  logic [1:0]    mem_byte_sel,
   input  logic          mem_we,
   input  logic          mem_re,
   output logic [31:0]   inst_o,
   output logic [31:0]   mem_rdata_o,
   output logic          halt,
   output logic          err,
   output logic [2:0]    fsm_state,
   mem_arbiter_if.master bus
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Debug encoding on fsm_state: 0 START, 1 DECIDE, 2 DATA, 3 FETCH, 4 COMMIT.
   typedef enum logic [2:0] {START, DECIDE, DATA, FETCH, COMMIT} state_t;

   state_t state, state_nxt;
   logic   load_data, load_fetch, latch_rd, latch_inst;
   logic   done, tmo_hit;

   assign bus.bus_req = (state == DATA) || (state == FETCH);
   assign halt        = (state != COMMIT);
   assign fsm_state   = state;
   assign done        = bus.bus_ack || tmo_hit;

   always_ff @(posedge clk) begin
      if (rst) state <= START;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_data  = 1'b0;
      load_fetch = 1'b0;
      latch_rd   = 1'b0;
      latch_inst = 1'b0;
      case (state)
         START: begin
            state_nxt  = FETCH;
            load_fetch = 1'b1;
         end
         DECIDE: begin
            if (mem_we || mem_re) begin
               state_nxt = DATA;
               load_data = 1'b1;
            end else begin
               state_nxt  = FETCH;
               load_fetch = 1'b1;
            end
         end
         DATA: begin
            // Completion goes straight to the fetch, keeping bus_req high.
            if (done) begin
               state_nxt  = FETCH;
               load_fetch = 1'b1;
               latch_rd   = !bus.bus_we;
            end
         end
         FETCH: begin
            if (done) begin
               state_nxt  = COMMIT;
               latch_inst = 1'b1;
            end
         end
         COMMIT:  state_nxt = DECIDE;
         default: state_nxt = START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.bus_addr     <= '0;
         bus.bus_wdata    <= '0;
         bus.bus_byte_sel <= '0;
         bus.bus_we       <= 1'b0;
         inst_o           <= NOP;
         mem_rdata_o      <= '0;
      end else begin
         if (load_data) begin
            bus.bus_addr     <= mem_addr;
            bus.bus_wdata    <= mem_wdata;
            bus.bus_byte_sel <= mem_byte_sel;
            bus.bus_we       <= mem_we;
         end else if (load_fetch) begin
            bus.bus_addr     <= fetch_addr;
            bus.bus_we       <= 1'b0;
            bus.bus_byte_sel <= 2'b10;
         end
         // An aborted transaction has no ack, so it returns the fill value.
         if (latch_rd)   mem_rdata_o <= bus.bus_ack ? bus.bus_rdata : 32'h0;
         if (latch_inst) inst_o      <= bus.bus_ack ? bus.bus_rdata : NOP;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // Abort in the 255th unacknowledged cycle of a DATA or FETCH visit.
   assign tmo_hit = bus.bus_req && !bus.bus_ack && (tmo_cnt == 8'd254);

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
         err     <= 1'b0;
      end else begin
         if (state_nxt != state)              tmo_cnt <= '0;
         else if (bus.bus_req && !bus.bus_ack) tmo_cnt <= tmo_cnt + 8'd1;
         if (tmo_hit) err <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a bus responder,
// a transaction-level reference model and an independent output monitor.
module tb_mem_arbiter;
   localparam logic [31:0] NOP = 32'h0000_0013;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_addr, mem_addr, mem_wdata;
   logic [1:0]  mem_byte_sel;
   logic        mem_we, mem_re;
   logic [31:0] inst_o, mem_rdata_o;
   logic        halt, err;
   logic [2:0]  fsm_state;

   mem_arbiter_if bus_if ();

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .fetch_addr(fetch_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_byte_sel(mem_byte_sel), .mem_we(mem_we), .mem_re(mem_re),
      .inst_o(inst_o), .mem_rdata_o(mem_rdata_o), .halt(halt), .err(err),
      .fsm_state(fsm_state), .bus(bus_if)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [67:0] bus_q[$];   // {check_wdata, addr, we, wdata, byte_sel}
   logic [80:0] exp_q[$];   // {err, cycles since previous commit (0 = unchecked), inst, rdata}
   int          delay_q[$]; // ack delay per bus transaction, in wait cycles
   logic [31:0] mem_init [logic [31:0]];
   logic [31:0] m_rdata;
   logic        m_err;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem_init.exists(a)) return mem_init[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_note(input string name, input string what);
      n_vec++;
      n_err++;
      $display("FAIL %s: %s", name, what);
   endtask

   // ---------------- reference model / driver tasks ----------------
   // One instruction: optional data access, then a fetch, then one commit cycle.
   task automatic issue(input logic [1:0] op, input logic [31:0] maddr, input logic [31:0] wdata,
                        input logic [1:0] bsel, input logic [31:0] faddr,
                        input int dd, input int df, input bit first);
      int          fc;
      int          gap;
      logic [31:0] inst;
      mem_we       = op[1];
      mem_re       = op[0];
      mem_addr     = maddr;
      mem_wdata    = wdata;
      mem_byte_sel = bsel;
      fetch_addr   = faddr;
      gap = 0;
      if (!first && op != 2'b00) begin
         bus_q.push_back({1'b1, maddr, op[1], wdata, bsel});
         delay_q.push_back(dd);
         if (op == 2'b01) m_rdata = mem_val(maddr);
         gap = dd + 1;
      end
      bus_q.push_back({1'b0, faddr, 1'b0, 32'h0, 2'b10});
      delay_q.push_back(df);
      fc   = df + 1;
      inst = mem_val(faddr);
`ifdef MEM_ARB_TIMEOUT_EN
      if (fc > 255) begin
         fc    = 255;
         inst  = NOP;
         m_err = 1'b1;
      end
`endif
      gap = first ? 0 : gap + fc + 2;
      exp_q.push_back({m_err, 16'(gap), inst, m_rdata});
   endtask

   task automatic wait_commit(input int limit);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (halt && c < limit);
      if (halt) fail_note("commit_timeout", "halt still 1, required a commit cycle");
   endtask

   task automatic check_reset();
      check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
      check("rst_halt", 32'(halt), 32'd1);
      check("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
      check("rst_bus_addr", bus_if.bus_addr, 32'd0);
      check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
      check("rst_bus_byte_sel", 32'(bus_if.bus_byte_sel), 32'd0);
      check("rst_inst_o", inst_o, NOP);
      check("rst_mem_rdata_o", mem_rdata_o, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_fsm_state", 32'(fsm_state), 32'd0);
   endtask

   // ---------------- bus responder ----------------
   int   r_cnt;
   logic r_prev_req, r_prev_ack;
   initial begin
      r_cnt = 0;
      r_prev_req = 1'b0;
      r_prev_ack = 1'b0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            r_cnt = 0;
            bus_if.bus_ack = ($urandom_range(0, 1) == 0);
            bus_if.bus_rdata = $urandom;
         end else if (bus_if.bus_req) begin
            if (!r_prev_req || r_prev_ack)
               r_cnt = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
            if (r_cnt == 0) begin
               bus_if.bus_ack   = 1'b1;
               bus_if.bus_rdata = mem_val(bus_if.bus_addr);
            end else begin
               r_cnt--;
               bus_if.bus_ack   = 1'b0;
               bus_if.bus_rdata = $urandom;
            end
         end else begin
            // Stray acks while idle must have no effect.
            bus_if.bus_ack   = ($urandom_range(0, 3) == 0);
            bus_if.bus_rdata = $urandom;
         end
         r_prev_req = bus_if.bus_req;
         r_prev_ack = bus_if.bus_ack;
      end
   end

   // ---------------- monitor ----------------
   logic [67:0] cur;
   logic [80:0] e;
   logic        cur_ok, m_prev_req, m_prev_ack;
   int          cyc, last_commit;
   initial begin
      cur = '0; e = '0; cur_ok = 1'b0;
      m_prev_req = 1'b0; m_prev_ack = 1'b0;
      cyc = 0; last_commit = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            m_prev_req = 1'b0;
            m_prev_ack = 1'b0;
         end else begin
            if (bus_if.bus_req) begin
               if (!m_prev_req || m_prev_ack) begin
                  cur_ok = (bus_q.size() != 0);
                  if (cur_ok) cur = bus_q.pop_front();
                  else fail_note("bus_unexpected", "bus_req=1, required no transaction");
               end
               if (cur_ok) begin
                  check("bus_addr", bus_if.bus_addr, cur[66:35]);
                  check("bus_we", 32'(bus_if.bus_we), 32'(cur[34]));
                  check("bus_byte_sel", 32'(bus_if.bus_byte_sel), 32'(cur[1:0]));
                  if (cur[67]) check("bus_wdata", bus_if.bus_wdata, cur[33:2]);
               end
            end
            if (!halt) begin
               if (exp_q.size() == 0) begin
                  fail_note("commit_unexpected", "halt=0, required halt=1");
               end else begin
                  e = exp_q.pop_front();
                  check("inst_o", inst_o, e[63:32]);
                  check("mem_rdata_o", mem_rdata_o, e[31:0]);
                  check("commit_err", 32'(err), 32'(e[80]));
                  check("commit_fsm_state", 32'(fsm_state), 32'd4);
                  if (e[79:64] != 16'd0) check("commit_cycles", 32'(cyc - last_commit), 32'(e[79:64]));
               end
               last_commit = cyc;
            end
            m_prev_req = bus_if.bus_req;
            m_prev_ack = bus_if.bus_ack;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] pc;
   initial begin
      rst = 1'b1;
      mem_we = 1'b0; mem_re = 1'b0; mem_addr = '0; mem_wdata = '0;
      mem_byte_sel = '0; fetch_addr = '0;
      m_rdata = '0; m_err = 1'b0;
      mem_init[32'h0000_0100] = 32'h0050_0093;
      mem_init[32'h0000_2004] = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      check_reset();

      // Directed opening: first fetch, load, delayed store, write+read, bare fetch.
      issue(2'b00, 32'h0, 32'h0, 2'b00, 32'h100, 0, 1, 1'b1);
      rst = 1'b0;
      wait_commit(50);
      issue(2'b01, 32'h2004, 32'h0, 2'b10, 32'h104, 0, 0, 1'b0);
      wait_commit(50);
      issue(2'b10, 32'h3000, 32'h1234_5678, 2'b00, 32'h108, 5, 0, 1'b0);
      wait_commit(50);
      issue(2'b11, 32'h3004, 32'hCAFE_F00D, 2'b01, 32'h10C, 2, 0, 1'b0);
      wait_commit(50);
      issue(2'b00, 32'h0, 32'h0, 2'b00, 32'h110, 0, 0, 1'b0);
      wait_commit(50);

      pc = 32'h114;
      for (int i = 0; i < 150; i++) begin
         issue(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, $urandom,
               2'($urandom_range(0, 2)), pc, $urandom_range(0, 6), $urandom_range(0, 6), 1'b0);
         wait_commit(50);
         if ($urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFF_FFFC;
         else                           pc = pc + 32'd4;
      end

      // Fetch that is never acknowledged, then reset during the fetch wait.
      issue(2'b00, 32'h0, 32'h0, 2'b00, 32'h400, 0, 1000, 1'b0);
`ifdef MEM_ARB_TIMEOUT_EN
      wait_commit(400);
      issue(2'b00, 32'h0, 32'h0, 2'b00, 32'h500, 0, 1000, 1'b0);
      repeat (20) @(negedge clk);
      check("stall_bus_addr", bus_if.bus_addr, 32'h500);
      check("stall_err", 32'(err), 32'd1);
`else
      repeat (300) @(negedge clk);
      check("stall_bus_addr", bus_if.bus_addr, 32'h400);
      check("stall_err", 32'(err), 32'd0);
`endif
      check("stall_halt", 32'(halt), 32'd1);
      check("stall_bus_req", 32'(bus_if.bus_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_reset();
      exp_q.delete();
      bus_q.delete();
      delay_q.delete();
      m_rdata = '0;
      m_err   = 1'b0;
      repeat (2) @(negedge clk);
      issue(2'b00, 32'h0, 32'h0, 2'b00, 32'h600, 0, $urandom_range(0, 4), 1'b1);
      rst = 1'b0;
      wait_commit(50);

      pc = 32'h604;
      for (int i = 0; i < 20; i++) begin
         issue(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, $urandom,
               2'($urandom_range(0, 2)), pc, $urandom_range(0, 6), $urandom_range(0, 6), 1'b0);
         wait_commit(50);
         pc = pc + 32'd4;
      end

      check("bus_q_drained", 32'(bus_q.size()), 32'd0);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      fail_note("watchdog", "simulation still running, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
